// File: rtl/regfile_write_queue.sv
// Write-side front end for the register file: queues writeback requests,
// drains one per cycle into the write port and forwards pending values to decode.
module regfile_write_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [ADDR_WIDTH-1:0]   inAddress,
    input  logic [DATA_WIDTH-1:0]   inData,
    input  logic                    drainEnable,
    output logic                    regWrite,
    output logic [ADDR_WIDTH-1:0]   writeAddress,
    output logic [DATA_WIDTH-1:0]   writeData,
    input  logic [ADDR_WIDTH-1:0]   readAddress1,
    input  logic [ADDR_WIDTH-1:0]   readAddress2,
    output logic                    fwdValid1,
    output logic [DATA_WIDTH-1:0]   fwdData1,
    output logic                    fwdValid2,
    output logic [DATA_WIDTH-1:0]   fwdData2,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];

    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic push, pop;

    assign inReady = (count_q != FULL);
    // Writes to register 0 complete the handshake but are dropped here.
    assign push    = inValid && inReady && (inAddress != '0);
    assign pop     = drainEnable && (count_q != '0);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        reg_write_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d      = head_q + 1'b1;
            reg_write_d = 1'b1;
            wr_addr_d   = fifo_addr_q[head_q];
            wr_data_d   = fifo_data_q[head_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Entry storage needs no reset: validity is derived from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= inAddress;
            fifo_data_q[tail_q] <= inData;
        end
    end

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic                  fwd_v   [2];
    logic [DATA_WIDTH-1:0] fwd_d   [2];

    assign rd_addr[0] = readAddress1;
    assign rd_addr[1] = readAddress2;

    // Priority by overwrite order: output stage first, then FIFO oldest to newest,
    // so the newest matching entry is what remains.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_v[p] = 1'b0;
            fwd_d[p] = '0;
            if (rd_addr[p] != '0) begin
                if (reg_write_q && (wr_addr_q == rd_addr[p])) begin
                    fwd_v[p] = 1'b1;
                    fwd_d[p] = wr_data_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if ((CW'(k) < count_q) &&
                        (fifo_addr_q[head_q + PW'(k)] == rd_addr[p])) begin
                        fwd_v[p] = 1'b1;
                        fwd_d[p] = fifo_data_q[head_q + PW'(k)];
                    end
                end
            end
        end
    end

    assign fwdValid1    = fwd_v[0];
    assign fwdData1     = fwd_d[0];
    assign fwdValid2    = fwd_v[1];
    assign fwdData2     = fwd_d[1];
    assign regWrite     = reg_write_q;
    assign writeAddress = wr_addr_q;
    assign writeData    = wr_data_q;
    assign count        = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: vector table plus reset and wrap sequences.
module tb_regfile_write_queue;
    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inAddress;
    logic [31:0] inData;
    logic        drainEnable;
    logic        regWrite;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [4:0]  readAddress1;
    logic [4:0]  readAddress2;
    logic        fwdValid1;
    logic [31:0] fwdData1;
    logic        fwdValid2;
    logic [31:0] fwdData2;
    logic [2:0]  count;

    int checks;
    int failures;

    regfile_write_queue dut (
        .clk          (clk),
        .reset        (reset),
        .inValid      (inValid),
        .inReady      (inReady),
        .inAddress    (inAddress),
        .inData       (inData),
        .drainEnable  (drainEnable),
        .regWrite     (regWrite),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .readAddress1 (readAddress1),
        .readAddress2 (readAddress2),
        .fwdValid1    (fwdValid1),
        .fwdData1     (fwdData1),
        .fwdValid2    (fwdValid2),
        .fwdData2     (fwdData2),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        de;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        rdy;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fv1;
        logic [31:0] fd1;
        logic        fv2;
        logic [31:0] fd2;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        inValid     = 1'b0;
        inAddress   = '0;
        inData      = '0;
        drainEnable = 1'b0;
        readAddress1 = '0;
        readAddress2 = '0;

        //            v     a      d             de    r1     r2     rdy   rw    wa     wd            fv1   fd1           fv2   fd2           cnt
        vecs[0]  = '{1'b1, 5'd1, 32'hAAAAAAAA, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd1, 5'd1, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA, 3'd1};
        vecs[2]  = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 5'd1, 32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA, 1'b0, 32'h00000000, 3'd0};
        vecs[3]  = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[4]  = '{1'b1, 5'd2, 32'h1234567A, 1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[5]  = '{1'b1, 5'd3, 32'h1234567B, 1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b1, 32'h1234567A, 1'b0, 32'h00000000, 3'd1};
        vecs[6]  = '{1'b1, 5'd4, 32'h1234567C, 1'b0, 5'd3, 5'd2, 1'b1, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b1, 32'h1234567B, 1'b1, 32'h1234567A, 3'd2};
        vecs[7]  = '{1'b1, 5'd5, 32'h1234567D, 1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b1, 32'h1234567C, 1'b0, 32'h00000000, 3'd3};
        vecs[8]  = '{1'b1, 5'd6, 32'h1234567E, 1'b0, 5'd5, 5'd6, 1'b0, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b1, 32'h1234567D, 1'b0, 32'h00000000, 3'd4};
        vecs[9]  = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd6, 5'd2, 1'b0, 1'b0, 5'd1, 32'hAAAAAAAA, 1'b0, 32'h00000000, 1'b1, 32'h1234567A, 3'd4};
        vecs[10] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 32'h1234567A, 1'b1, 32'h1234567A, 1'b1, 32'h1234567B, 3'd3};
        vecs[11] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd2, 5'd0, 1'b1, 1'b1, 5'd3, 32'h1234567B, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd2};
        vecs[12] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd4, 32'h1234567C, 1'b1, 32'h1234567C, 1'b1, 32'h1234567D, 3'd1};
        vecs[13] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd5, 5'd4, 1'b1, 1'b1, 5'd5, 32'h1234567D, 1'b1, 32'h1234567D, 1'b0, 32'h00000000, 3'd0};
        vecs[14] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 32'h1234567D, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[15] = '{1'b1, 5'd2, 32'hBBBBBBBB, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 5'd5, 32'h1234567D, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[16] = '{1'b1, 5'd2, 32'h12345678, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 5'd5, 32'h1234567D, 1'b1, 32'hBBBBBBBB, 1'b1, 32'hBBBBBBBB, 3'd1};
        vecs[17] = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd2, 5'd2, 1'b1, 1'b0, 5'd5, 32'h1234567D, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 3'd2};
        vecs[18] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd2, 5'd2, 1'b1, 1'b0, 5'd5, 32'h1234567D, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 3'd2};
        vecs[19] = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 32'hBBBBBBBB, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 3'd1};
        vecs[20] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd2, 5'd2, 1'b1, 1'b0, 5'd2, 32'hBBBBBBBB, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 3'd1};
        vecs[21] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 3'd0};
        vecs[22] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 5'd2, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[23] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};
        vecs[24] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 3'd0};

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",    32'(count), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_wa",       32'(writeAddress), 32'd0);
        chk("rst_wd",       writeData, 32'd0);
        chk("rst_inReady",  32'(inReady), 32'd1);
        chk("rst_fwdValid1", 32'(fwdValid1), 32'd0);
        reset = 1'b0;
        tick();

        // Table-driven vectors: outputs checked before the edge that applies the inputs
        for (int i = 0; i < 25; i++) begin
            inValid      = vecs[i].v;
            inAddress    = vecs[i].a;
            inData       = vecs[i].d;
            drainEnable  = vecs[i].de;
            readAddress1 = vecs[i].r1;
            readAddress2 = vecs[i].r2;
            #1;
            chk($sformatf("v%0d_inReady", i),  32'(inReady),      32'(vecs[i].rdy));
            chk($sformatf("v%0d_regWrite", i), 32'(regWrite),     32'(vecs[i].rw));
            chk($sformatf("v%0d_wa", i),       32'(writeAddress), 32'(vecs[i].wa));
            chk($sformatf("v%0d_wd", i),       writeData,         vecs[i].wd);
            chk($sformatf("v%0d_fv1", i),      32'(fwdValid1),    32'(vecs[i].fv1));
            chk($sformatf("v%0d_fd1", i),      fwdData1,          vecs[i].fd1);
            chk($sformatf("v%0d_fv2", i),      32'(fwdValid2),    32'(vecs[i].fv2));
            chk($sformatf("v%0d_fd2", i),      fwdData2,          vecs[i].fd2);
            chk($sformatf("v%0d_count", i),    32'(count),        32'(vecs[i].cnt));
            tick();
        end

        // Mid-operation reset: 3 queued, one popped -> count=2 with regWrite high
        drainEnable = 1'b0;
        for (int n = 7; n <= 9; n++) begin
            inValid   = 1'b1;
            inAddress = 5'(n);
            inData    = 32'hD0D00000 + 32'(n);
            tick();
        end
        inValid     = 1'b0;
        drainEnable = 1'b1;
        tick();
        drainEnable  = 1'b0;
        readAddress1 = 5'd8;
        readAddress2 = 5'd7;
        #1;
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_regWrite", 32'(regWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_count",    32'(count), 32'd0);
        chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
        chk("mid_rst_inReady",  32'(inReady), 32'd1);
        chk("mid_rst_fv1",      32'(fwdValid1), 32'd0);
        chk("mid_rst_fv2",      32'(fwdValid2), 32'd0);
        chk("mid_rst_wd",       writeData, 32'd0);
        #1;
        reset = 1'b0;
        drainEnable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("post_rst_regWrite_c%0d", c), 32'(regWrite), 32'd0);
            chk($sformatf("post_rst_count_c%0d", c), 32'(count), 32'd0);
        end

        // Back-to-back pushes with continuous drain; pointers wrap past DEPTH
        readAddress1 = 5'd0;
        readAddress2 = 5'd0;
        for (int i = 0; i < 12; i++) begin
            inValid   = (i < 10);
            inAddress = 5'(i + 1);
            inData    = 32'hC0DE0000 + 32'(i + 1);
            #1;
            chk($sformatf("wrap%0d_count", i), 32'(count), (i >= 1 && i <= 10) ? 32'd1 : 32'd0);
            chk($sformatf("wrap%0d_regWrite", i), 32'(regWrite), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) begin
                chk($sformatf("wrap%0d_wa", i), 32'(writeAddress), 32'(i - 1));
                chk($sformatf("wrap%0d_wd", i), writeData, 32'hC0DE0000 + 32'(i - 1));
            end
            tick();
        end
        inValid = 1'b0;
        #1;
        chk("wrap_end_regWrite", 32'(regWrite), 32'd0);
        chk("wrap_end_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the 32x32 register file write port (regWrite / writeAddress / writeData).
- Buffers writeback requests from the pipeline in a small FIFO and drains at most one per cycle into the register file.
- Forwards pending, not-yet-committed values to the two register read addresses, so decode sees the newest data.
- Sits between the writeback stage and Registers; read ports of Registers remain connected directly to decode.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, >= 2.
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- inValid  input  1  writeback request valid.
- inReady  output  1  queue can accept a request this cycle.
- inAddress  input  ADDR_WIDTH  destination register of request.
- inData  input  DATA_WIDTH  data of request.
- drainEnable  input  1  register file write port available this cycle.
- regWrite  output  1  write strobe to register file.
- writeAddress  output  ADDR_WIDTH  write address to register file.
- writeData  output  DATA_WIDTH  write data to register file.
- readAddress1  input  ADDR_WIDTH  decode read address 1 (snooped).
- readAddress2  input  ADDR_WIDTH  decode read address 2 (snooped).
- fwdValid1  output  1  pending value exists for readAddress1.
- fwdData1  output  DATA_WIDTH  forwarded value for readAddress1.
- fwdValid2  output  1  pending value exists for readAddress2.
- fwdData2  output  DATA_WIDTH  forwarded value for readAddress2.
- count  output  clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (async, active-high, immediate):
  - head, tail and count = 0; all entries invalid.
  - regWrite = 0, writeAddress = 0, writeData = 0.
  - fwdValid1/2 = 0 and fwdData1/2 = 0.
  - Reset mid-operation discards all pending writes; no partial commit.
- Push:
  - Handshake completes at the edge where inValid && inReady.
  - inReady = (count != DEPTH), combinational from registered count only; no same-cycle pass-through when full.
  - A push with inAddress == 0 completes the handshake but is discarded: not enqueued, count unchanged.
- Pop:
  - At an edge where drainEnable && count > 0 (pre-edge count), the head entry is loaded into the output registers, regWrite = 1 for exactly one cycle, and head advances.
  - Otherwise regWrite = 0 after the edge; writeAddress/writeData hold their last values.
- Latency: a request accepted at edge N can appear on regWrite at the earliest after edge N+1. A push into an empty queue is never popped at the same edge.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged; head and tail both advance.
- Pointers wrap modulo DEPTH. count is saturation-free by construction (push blocked when full, pop blocked when empty).
- Forwarding (combinational, per read port independently):
  - Candidates: valid FIFO entries, plus the output stage while regWrite = 1 (its value is committed by Registers only at the next edge).
  - Youngest match wins: newest FIFO entry first, oldest FIFO entry next, output stage last.
  - readAddress == 0 never forwards: fwdValid = 0, fwdData = 0.
  - No match: fwdValid = 0, fwdData = 0.
- drainEnable low with a full queue: state holds indefinitely; inReady = 0; forwarding remains active.

Test Plan:
- Reset: assert reset mid-cycle with count = 2 -> immediately count = 0, regWrite = 0, inReady = 1, fwdValid1 = fwdValid2 = 0; after release, no write of the old entries ever appears.
- Single write: push addr 1 = 32'hAAAAAAAA at edge 1 with drainEnable = 1 -> regWrite = 1, writeAddress = 1, writeData = AAAAAAAA after edge 2 for one cycle; readAddress1 = 1 gives fwdValid1 = 1, fwdData1 = AAAAAAAA from after edge 1 until after edge 3.
- Full and stall: drainEnable = 0, push addr 2..5 with data 32'h12345678 + n -> count = 4, inReady = 0; a fifth inValid is not accepted; raising drainEnable drains 2, 3, 4, 5 on four consecutive cycles in order.
- Youngest forwarding: queue addr 2 = 32'hBBBBBBBB then addr 2 = 32'h12345678 -> readAddress1 = readAddress2 = 2 gives fwdData1 = fwdData2 = 12345678.
- Zero register: push addr 0 = 32'hFFFFFFFF -> handshake completes, count stays 0, regWrite never asserted; readAddress1 = 0 gives fwdValid1 = 0.
- Wrap and concurrency: 10 back-to-back pushes (addr 1..10) with drainEnable = 1 every cycle -> count never exceeds 1, writes emerge in order with 1-cycle latency, and pointers wrap past DEPTH without loss or duplication.
